// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the word memory responder.
package mem_resp_pkg;

  localparam int MR_DEPTH  = 64;
  localparam int MR_ADDR_W = 6;
  localparam int MR_DATA_W = 32;

  // Transaction sequencing states; see mem_responder for the meaning of each.
  typedef enum logic [2:0] {
    INIT  = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    RESP  = 3'd5
  } mr_state_e;

  // Expand four byte-lane enables into a 32-bit bit mask (lane i -> bits [8i+7:8i]).
  function automatic logic [MR_DATA_W-1:0] lane_mask(input logic [3:0] be);
    logic [MR_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Single-port word store: synchronous write, registered read (one-cycle latency).
// A read in the same cycle as a write to the same word returns the old word.
module ram_core #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Array write and read-before-write output register share the one address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Req/Ack word memory responder: clears the store after reset, then serves
// word reads, full-word writes and byte-enabled read-modify-write updates.
//
// state | meaning
// INIT  | clear sweep, one word per cycle, Busy high, Req ignored
// IDLE  | waiting for Req; array address follows Mem_Addr
// RD    | array word for the latched address is available / re-read
// MERGE | combine old word with latched lanes and write it back
// WR    | write the latched full word
// RESP  | Ack pulse, M_R_Data shows the read or stored word
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH  = MR_DEPTH,
  parameter int ADDR_W = MR_ADDR_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Req,
  input  logic                 Mem_Write,
  input  logic [ADDR_W-1:0]    Mem_Addr,
  input  logic [3:0]           Byte_En,
  input  logic [MR_DATA_W-1:0] M_W_Data,
  output logic [MR_DATA_W-1:0] M_R_Data,
  output logic                 Ack,
  output logic                 Busy
);

  mr_state_e state_q, state_d;

  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [3:0]           be_q, be_d;
  logic [MR_DATA_W-1:0] wdata_q, wdata_d;
  logic [MR_DATA_W-1:0] rdata_q, rdata_d;
  logic                 ack_q;
  logic                 busy_q;

  logic                 ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [MR_DATA_W-1:0] ram_wdata;
  logic [MR_DATA_W-1:0] ram_rdata;
  logic [MR_DATA_W-1:0] mask;
  logic [MR_DATA_W-1:0] merged;

  ram_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (MR_DATA_W)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // In MERGE the array output holds the old word read during RD.
  assign mask   = lane_mask(be_q);
  assign merged = (ram_rdata & ~mask) | (wdata_q & mask);

  // Next-state logic and array port mux; the sweep, RD, WR and MERGE share one port.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;

    unique case (state_q)
      INIT: begin
        ram_we    = 1'b1;
        ram_addr  = idx_q;
        ram_wdata = '0;
        idx_d     = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Presenting Mem_Addr here lets the accept edge fetch the word, so the
        // read data is already registered by the time RD decides the response.
        ram_addr = Mem_Addr;
        if (Req) begin
          wr_d    = Mem_Write;
          addr_d  = Mem_Addr;
          be_d    = Byte_En;
          wdata_d = M_W_Data;
          if (Mem_Write && (Byte_En == 4'b1111)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (wr_q) begin
          state_d = MERGE;
        end else begin
          rdata_d = ram_rdata;
          state_d = RESP;
        end
      end
      MERGE: begin
        ram_we    = 1'b1;
        ram_wdata = merged;
        rdata_d   = merged;
        state_d   = RESP;
      end
      WR: begin
        ram_we  = 1'b1;
        rdata_d = wdata_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  // State, latched request and registered outputs; reset restarts the sweep.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= INIT;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= (state_d == RESP);
      busy_q  <= (state_d == INIT);
    end
  end

  assign M_R_Data = rdata_q;
  assign Ack      = ack_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table plus multi-cycle sequences.
module tb_mem_responder;

  logic        Clk;
  logic        Rst;
  logic        Req;
  logic        Mem_Write;
  logic [5:0]  Mem_Addr;
  logic [3:0]  Byte_En;
  logic [31:0] M_W_Data;
  logic [31:0] M_R_Data;
  logic        Ack;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.DEPTH(64), .ADDR_W(6)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Req),
    .Mem_Write (Mem_Write),
    .Mem_Addr  (Mem_Addr),
    .Byte_En   (Byte_En),
    .M_W_Data  (M_W_Data),
    .M_R_Data  (M_R_Data),
    .Ack       (Ack),
    .Busy      (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered at a negedge inside a reset-induced INIT cycle with Rst high.
  // Returns at the first negedge with Busy low (an IDLE cycle).
  task automatic sweep_check(input string tag);
    int  n;
    bit  ack_seen;
    chk({tag, " reset Busy"}, 32'(Busy), 32'd1);
    chk({tag, " reset Ack"}, 32'(Ack), 32'd0);
    chk({tag, " reset M_R_Data"}, M_R_Data, 32'h0);
    Rst = 1'b0;
    n = 1;
    ack_seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clk);
      if (Ack) ack_seen = 1'b1;
      if (!Busy) break;
      n++;
    end
    chk({tag, " busy cycles"}, 32'(n), 32'd64);
    chk({tag, " no Ack in sweep"}, 32'(ack_seen), 32'd0);
  endtask

  // Issues one transaction in the next (IDLE) cycle and checks latency, data
  // and that Ack lasts one cycle.
  task automatic txn(input int id, input vec_t v);
    int lat;
    @(negedge Clk);
    Req = 1'b1;
    Mem_Write = v.wr;
    Mem_Addr = v.addr;
    Byte_En = v.be;
    M_W_Data = v.wdata;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (Ack) begin
        lat = k;
        break;
      end
    end
    Req = 1'b0;
    chk($sformatf("vec%0d latency", id), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("vec%0d data", id), M_R_Data, v.exp_data);
    @(negedge Clk);
    chk($sformatf("vec%0d ack pulse", id), 32'(Ack), 32'd0);
  endtask

  initial begin
    int k;
    vecs[0]  = '{1'b0, 6'h3F, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2};
    vecs[1]  = '{1'b1, 6'h05, 4'b1111, 32'h1111_2222, 32'h1111_2222, 2};
    vecs[2]  = '{1'b0, 6'h05, 4'b0000, 32'h0000_0000, 32'h1111_2222, 2};
    vecs[3]  = '{1'b1, 6'h05, 4'b0011, 32'h3333_6666, 32'h1111_6666, 3};
    vecs[4]  = '{1'b1, 6'h05, 4'b1000, 32'haaaa_ffff, 32'haa11_6666, 3};
    vecs[5]  = '{1'b1, 6'h05, 4'b0000, 32'hdead_beef, 32'haa11_6666, 3};
    vecs[6]  = '{1'b0, 6'h05, 4'b1111, 32'h0000_0000, 32'haa11_6666, 2};
    vecs[7]  = '{1'b1, 6'h01, 4'b1111, 32'h0101_0101, 32'h0101_0101, 2};
    vecs[8]  = '{1'b1, 6'h02, 4'b1111, 32'h0202_0202, 32'h0202_0202, 2};
    vecs[9]  = '{1'b1, 6'h02, 4'b0100, 32'h00ff_0000, 32'h02ff_0202, 3};
    vecs[10] = '{1'b1, 6'h3F, 4'b0110, 32'h1234_5678, 32'h0034_5600, 3};
    vecs[11] = '{1'b0, 6'h3F, 4'b0000, 32'h0000_0000, 32'h0034_5600, 2};
    vecs[12] = '{1'b0, 6'h00, 4'b0000, 32'h0000_0000, 32'h0000_0000, 2};

    Rst = 1'b1;
    Req = 1'b0;
    Mem_Write = 1'b0;
    Mem_Addr = '0;
    Byte_En = '0;
    M_W_Data = '0;
    repeat (3) @(negedge Clk);
    sweep_check("por");

    for (int i = 0; i < 13; i++) begin
      txn(i, vecs[i]);
    end

    // Held Req: read addr 1, switch to addr 2 in the Ack cycle.
    @(negedge Clk);
    Req = 1'b1;
    Mem_Write = 1'b0;
    Mem_Addr = 6'h01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      chk($sformatf("b2b ack c%0d", c), 32'(Ack), ((c == 2) || (c == 5)) ? 32'd1 : 32'd0);
      if (c == 2) begin
        chk("b2b data addr1", M_R_Data, 32'h0101_0101);
        Mem_Addr = 6'h02;
      end
      if (c == 5) begin
        chk("b2b data addr2", M_R_Data, 32'h02ff_0202);
      end
    end
    Req = 1'b0;
    @(negedge Clk);

    // Reset in MERGE of a partial write to addr 7; Req held through the sweep.
    @(negedge Clk);
    Req = 1'b1;
    Mem_Write = 1'b1;
    Mem_Addr = 6'h07;
    Byte_En = 4'b0011;
    M_W_Data = 32'hffff_ffff;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort no ack before reset", 32'(Ack), 32'd0);
    Rst = 1'b1;
    Mem_Write = 1'b0;
    @(negedge Clk);
    sweep_check("abort");
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (Ack) begin
        k = c;
        break;
      end
    end
    Req = 1'b0;
    chk("post-sweep read latency", 32'(k), 32'd2);
    chk("post-sweep read addr7", M_R_Data, 32'h0000_0000);
    @(negedge Clk);
    chk("post-sweep ack pulse", 32'(Ack), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
